tdm_demux8: RTL and testbench

//  Receive-side partner of the 8:1 mux: a time-division demultiplexer. A serial slot

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_demux8_if.sv | 30 +++
 rtl/tdm_demux8.sv | 114 +++++++++++
 tb/tb_tdm_demux8.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Brief    : Shared TDM framing constants and state encodings (mux and demux).
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    localparam int NCH    = 8;
    localparam int SLOT_W = 3;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_demux8_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tdm_demux8_if
// Brief    : Slot stream in / parallel frame out bundle of the TDM demux.
// Revision : 1.0 - initial release
// ============================================================================
interface tdm_demux8_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]                         din;
    logic                                     din_valid;
    logic                                     frame_sync;
    logic [tdm_pkg::NCH*WIDTH-1:0]            dout;
    logic                                     dout_valid;
    logic [tdm_pkg::SLOT_W-1:0]               slot;
    logic                                     locked;
    logic                                     sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  dout, dout_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, dout_valid, slot, locked, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tdm_demux8
// Brief    : 8-slot TDM demultiplexer; publishes each complete frame in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    tdm_demux8_if.slave bus
);

    localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(NCH - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SLOT_W-1:0]        r_slot;
    logic [SLOT_W-1:0]        w_slot_nxt;
    logic [SLOT_W-1:0]        w_wr_idx;
    logic                     w_wr_en;
    logic                     w_err;
    logic                     w_publish;
    logic [WIDTH-1:0]         r_shadow [NCH-1];
    logic [NCH*WIDTH-1:0]     r_dout;
    logic [NCH*WIDTH-1:0]     w_frame;
    logic                     r_dout_valid;
    logic                     r_sync_err;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wr_idx    = r_slot;
        w_wr_en     = 1'b0;
        w_err       = 1'b0;
        w_publish   = 1'b0;
        if (bus.din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (bus.frame_sync) begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = '0;
                        w_slot_nxt  = SLOT_W'(1);
                        w_state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (bus.frame_sync) begin
                        // A sync anywhere but slot 0 drops the partial frame and restarts it here
                        w_err      = (r_slot != '0);
                        w_wr_en    = 1'b1;
                        w_wr_idx   = '0;
                        w_slot_nxt = SLOT_W'(1);
                    end else if (r_slot == '0) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_slot_nxt = r_slot + SLOT_W'(1);
                        w_publish  = (r_slot == c_last_slot);
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    // The final slot bypasses the shadow bank and lands directly in dout
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < NCH - 1; k++) begin
            w_frame[k*WIDTH +: WIDTH] = r_shadow[k];
        end
        w_frame[(NCH-1)*WIDTH +: WIDTH] = bus.din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_slot       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sync_err   <= 1'b0;
            for (int k = 0; k < NCH - 1; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_dout_valid <= w_publish;
            r_sync_err   <= w_err;
            for (int k = 0; k < NCH - 1; k++) begin
                if (w_wr_en && (w_wr_idx == SLOT_W'(k))) begin
                    r_shadow[k] <= bus.din;
                end
            end
            if (w_publish) begin
                r_dout <= w_frame;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.slot       = r_slot;
    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux8
// Brief    : Scoreboard bench for tdm_demux8 (WIDTH=1 and WIDTH=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } ev_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_vec  = 0;
    int          n_miss = 0;
    ev_t         q1[$];
    ev_t         q4[$];
    logic [7:0]  exp1 = '0;
    logic [31:0] exp4 = '0;

    tdm_demux8_if #(.WIDTH(1)) b1();
    tdm_demux8_if #(.WIDTH(4)) b4();

    tdm_demux8 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    tdm_demux8 #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop an expected event whenever a pulse appears; dout must match the model every cycle
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) exp1 = '0;
        chk("dut1 pulse exclusivity", {31'b0, b1.dout_valid & b1.sync_err}, 32'd0);
        if (b1.dout_valid || b1.sync_err) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected pulse", {30'b0, b1.sync_err, b1.dout_valid}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1 event kind", {31'b0, b1.sync_err}, {31'b0, e.err});
                if (!e.err) exp1 = e.data[7:0];
            end
        end
        chk("dut1 dout value", {24'b0, b1.dout}, {24'b0, exp1});
    end

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) exp4 = '0;
        chk("dut4 pulse exclusivity", {31'b0, b4.dout_valid & b4.sync_err}, 32'd0);
        if (b4.dout_valid || b4.sync_err) begin
            if (q4.size() == 0) begin
                chk("dut4 unexpected pulse", {30'b0, b4.sync_err, b4.dout_valid}, 32'd0);
            end else begin
                e = q4.pop_front();
                chk("dut4 event kind", {31'b0, b4.sync_err}, {31'b0, e.err});
                if (!e.err) exp4 = e.data;
            end
        end
        chk("dut4 dout value", b4.dout, exp4);
    end

    task automatic beat1(input logic d, input logic fs, input int gap);
        b1.din        = d;
        b1.frame_sync = fs;
        b1.din_valid  = 1'b1;
        @(posedge clk); #1;
        b1.din_valid  = 1'b0;
        b1.frame_sync = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic beat4(input logic [3:0] d, input logic fs);
        b4.din        = d;
        b4.frame_sync = fs;
        b4.din_valid  = 1'b1;
        @(posedge clk); #1;
        b4.din_valid  = 1'b0;
        b4.frame_sync = 1'b0;
    endtask

    task automatic frame1(input logic [7:0] bits, input int gap);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) q1.push_back('{err: 1'b0, data: {24'b0, bits}});
            beat1(bits[k], (k == 0), gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b1.din = '0; b1.din_valid = 1'b0; b1.frame_sync = 1'b0;
        b4.din = '0; b4.din_valid = 1'b0; b4.frame_sync = 1'b0;
        #12;
        chk("reset dout",       {24'b0, b1.dout}, 32'd0);
        chk("reset dout_valid", {31'b0, b1.dout_valid}, 32'd0);
        chk("reset slot",       {29'b0, b1.slot}, 32'd0);
        chk("reset locked",     {31'b0, b1.locked}, 32'd0);
        chk("reset sync_err",   {31'b0, b1.sync_err}, 32'd0);
        chk("reset dout4",      b4.dout, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame after reset; dout_valid must be up right after the slot-7 edge
        frame1(8'b0100_1101, 0);
        chk("t1 latency dout_valid", {31'b0, b1.dout_valid}, 32'd1);
        chk("t1 dout",   {24'b0, b1.dout}, 32'h4D);
        chk("t1 locked", {31'b0, b1.locked}, 32'd1);
        chk("t1 slot",   {29'b0, b1.slot}, 32'd0);
        @(posedge clk); #1;
        chk("t1 pulse width", {31'b0, b1.dout_valid}, 32'd0);

        // Gapped back-to-back frame; the monitor checks dout holds 4D meanwhile
        frame1(8'hFF, 1);
        chk("t2 dout", {24'b0, b1.dout}, 32'hFF);

        // Early sync at slot 4
        beat1(1'b1, 1'b1, 0);
        repeat (3) beat1(1'b1, 1'b0, 0);
        chk("t3 slot before early sync", {29'b0, b1.slot}, 32'd4);
        q1.push_back('{err: 1'b1, data: 32'd0});
        beat1(1'b0, 1'b1, 0);
        chk("t3 sync_err",   {31'b0, b1.sync_err}, 32'd1);
        chk("t3 no valid",   {31'b0, b1.dout_valid}, 32'd0);
        chk("t3 slot",       {29'b0, b1.slot}, 32'd1);
        chk("t3 locked",     {31'b0, b1.locked}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            logic [7:0] bits;
            bits = 8'b1101_0110;
            if (k == 7) q1.push_back('{err: 1'b0, data: 32'hD6});
            beat1(bits[k], 1'b0, 0);
        end
        chk("t3 resync dout_valid", {31'b0, b1.dout_valid}, 32'd1);

        // Missing sync at slot 0 drops lock; unsynced beats ignored
        q1.push_back('{err: 1'b1, data: 32'd0});
        beat1(1'b1, 1'b0, 0);
        chk("t4 sync_err", {31'b0, b1.sync_err}, 32'd1);
        chk("t4 locked",   {31'b0, b1.locked}, 32'd0);
        chk("t4 slot",     {29'b0, b1.slot}, 32'd0);
        repeat (3) beat1(1'b1, 1'b0, 0);
        chk("t4 hunt locked", {31'b0, b1.locked}, 32'd0);
        chk("t4 hunt slot",   {29'b0, b1.slot}, 32'd0);
        frame1(8'hF0, 0);
        chk("t4 relock", {31'b0, b1.locked}, 32'd1);

        // Async reset between edges at slot 5
        beat1(1'b1, 1'b1, 0);
        repeat (4) beat1(1'b0, 1'b0, 0);
        chk("t5 slot before reset", {29'b0, b1.slot}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 dout",       {24'b0, b1.dout}, 32'd0);
        chk("t5 dout_valid", {31'b0, b1.dout_valid}, 32'd0);
        chk("t5 slot",       {29'b0, b1.slot}, 32'd0);
        chk("t5 locked",     {31'b0, b1.locked}, 32'd0);
        chk("t5 sync_err",   {31'b0, b1.sync_err}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        beat1(1'b1, 1'b0, 0);
        chk("t5 hunt locked",   {31'b0, b1.locked}, 32'd0);
        chk("t5 hunt sync_err", {31'b0, b1.sync_err}, 32'd0);
        frame1(8'h53, 0);
        chk("t5 dout", {24'b0, b1.dout}, 32'h53);

        // WIDTH=4 instance
        for (int k = 0; k < 8; k++) begin
            if (k == 7) q4.push_back('{err: 1'b0, data: 32'hFEDC_BA98});
            beat4(4'(k + 8), (k == 0));
        end
        chk("t6 dout_valid", {31'b0, b4.dout_valid}, 32'd1);
        chk("t6 dout",       b4.dout, 32'hFEDC_BA98);
        chk("t6 locked",     {31'b0, b4.locked}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("dut1 pending events", q1.size(), 32'd0);
        chk("dut4 pending events", q4.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
